// File: rtl/rv32i_pkg.sv
// rv32i_pkg: control-bundle layout, forwarding encodings and opcodes shared by the
// pipeline control slice, plus the register-match helpers used for hazards and forwarding.
package rv32i_pkg;
    localparam int CTRL_W       = 10;
    localparam int B_BRANCH     = 9;
    localparam int B_JUMP       = 8;
    localparam int B_PC_ULA     = 7;
    localparam int B_ULA_OP_HI  = 6;
    localparam int B_ULA_OP_LO  = 5;
    localparam int B_MUX_ULA    = 4;
    localparam int B_MUX_REG_WR = 3;
    localparam int B_REG_WR     = 2;
    localparam int B_MEM_WR     = 1;
    localparam int B_MEM_RD     = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // x0 is hardwired, so a write to it never produces a value worth waiting for
    function automatic logic reg_hit(input logic v, input logic wr, input logic [4:0] rd,
                                     input logic [4:0] rs);
        return v && wr && rd != 5'd0 && rd == rs;
    endfunction

    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        return mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational stall and operand-forwarding selection.
// FORWARD_EN selects bypassing from MEM/WB; without it, RAW hazards on EX/MEM stall instead.
module hazard_detect
    import rv32i_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_rd,
    input  logic       ex_reg_wr,
    input  logic [4:0] ex_rd,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic       mem_valid,
    input  logic       mem_reg_wr,
    input  logic [4:0] mem_rd,
    input  logic       wb_valid,
    input  logic       wb_reg_wr,
    input  logic [4:0] wb_rd,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);
    logic load_use, raw;
`ifdef FORWARD_EN
    logic unused_ok;
    assign unused_ok = ex_reg_wr;
`else
    logic unused_ok;
    assign unused_ok = ^{ex_rs1, ex_rs2, wb_valid, wb_reg_wr, wb_rd};
`endif
    always_comb begin
        load_use = id_valid && (reg_hit(ex_valid, ex_mem_rd, ex_rd, id_rs1) ||
                                reg_hit(ex_valid, ex_mem_rd, ex_rd, id_rs2));
`ifdef FORWARD_EN
        raw       = 1'b0;
        fwd_a_sel = fwd_pick(reg_hit(mem_valid, mem_reg_wr, mem_rd, ex_rs1),
                             reg_hit(wb_valid, wb_reg_wr, wb_rd, ex_rs1));
        fwd_b_sel = fwd_pick(reg_hit(mem_valid, mem_reg_wr, mem_rd, ex_rs2),
                             reg_hit(wb_valid, wb_reg_wr, wb_rd, ex_rs2));
`else
        // WB is left out: the register file writes before it reads
        raw = id_valid && (reg_hit(ex_valid, ex_reg_wr, ex_rd, id_rs1) ||
                           reg_hit(ex_valid, ex_reg_wr, ex_rd, id_rs2) ||
                           reg_hit(mem_valid, mem_reg_wr, mem_rd, id_rs1) ||
                           reg_hit(mem_valid, mem_reg_wr, mem_rd, id_rs2));
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
`endif
        stall = (load_use || raw) && !flush;
    end
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: EX/MEM/WB control-bundle pipeline with bubble insertion on stall/flush.
// Build option FORWARD_EN enables MEM/WB forwarding in hazard_detect.
module ctrl_pipeline
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              ex_branch_taken,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [4:0]        ex_rd_addr,
    output logic [4:0]        mem_rd_addr,
    output logic [4:0]        wb_rd_addr,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);
    logic       ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
    ctrl_t      ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
    logic [4:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic [4:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic       bubble;

    assign flush = ex_valid_q && ex_branch_taken;

    hazard_detect u_hazard (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (ex_valid_q),
        .ex_mem_rd  (ex_ctrl_q[B_MEM_RD]),
        .ex_reg_wr  (ex_ctrl_q[B_REG_WR]),
        .ex_rd      (ex_rd_q),
        .ex_rs1     (ex_rs1_q),
        .ex_rs2     (ex_rs2_q),
        .mem_valid  (mem_valid_q),
        .mem_reg_wr (mem_ctrl_q[B_REG_WR]),
        .mem_rd     (mem_rd_q),
        .wb_valid   (wb_valid_q),
        .wb_reg_wr  (wb_ctrl_q[B_REG_WR]),
        .wb_rd      (wb_rd_q),
        .flush      (flush),
        .stall      (stall),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel)
    );

    always_comb begin
        bubble      = stall || flush;
        ex_valid_d  = id_valid && !bubble;
        ex_ctrl_d   = bubble ? '0 : id_ctrl;
        // conditional branches never write back, whatever the decoder asserted
        ex_ctrl_d[B_REG_WR] = ex_ctrl_d[B_REG_WR] && !(id_ctrl[B_BRANCH] && !id_ctrl[B_JUMP]);
        ex_rd_d     = bubble ? 5'd0 : id_rd;
        ex_rs1_d    = bubble ? 5'd0 : id_rs1;
        ex_rs2_d    = bubble ? 5'd0 : id_rs2;
        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = ex_ctrl_q;
        mem_rd_d    = ex_rd_q;
        wb_valid_d  = mem_valid_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_rd_d     = mem_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= 5'd0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= 5'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign mem_valid   = mem_valid_q;
    assign wb_valid    = wb_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign mem_ctrl    = mem_ctrl_q;
    assign wb_ctrl     = wb_ctrl_q;
    assign ex_rd_addr  = ex_rd_q;
    assign mem_rd_addr = mem_rd_q;
    assign wb_rd_addr  = wb_rd_q;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed hazard/forwarding scenarios with a WB scoreboard.
// Expectations follow the FORWARD_EN build option.
module tb_ctrl_pipeline;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [9:0] LW  = 10'h01D;
    localparam logic [9:0] ADD = 10'h044;
    localparam logic [9:0] BEQ = 10'h224;
    localparam logic [9:0] JAL = 10'h384;

    typedef struct packed {
        logic [9:0] ctrl;
        logic [4:0] rd;
    } wb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [9:0] id_ctrl = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       ex_branch_taken = 1'b0;
    logic       ex_valid, mem_valid, wb_valid, stall, flush;
    logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    int         n_chk = 0, n_pass = 0;
    wb_t        sb[$];

    ctrl_pipeline dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
        .stall(stall), .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [9:0] wb_expect(input logic [9:0] c);
        logic [9:0] r;
        r = c;
        if (c[9] && !c[8]) r[2] = 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] all_outputs();
        return {ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl, ex_rd_addr,
                mem_rd_addr, wb_rd_addr, stall, flush, fwd_a_sel, fwd_b_sel};
    endfunction

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", wb_valid, 1'b0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_ctrl", wb_ctrl, e.ctrl);
                check("wb_rd", wb_rd_addr, e.rd);
            end
        end
    end

    task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] s1, s2, d);
        id_valid = v;
        id_ctrl  = c;
        id_rs1   = s1;
        id_rs2   = s2;
        id_rd    = d;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, '0, '0);
        repeat (n) advance();
    endtask

    task automatic issue(input logic v, input logic [9:0] c, input logic [4:0] s1, s2, d,
                         input int n);
        drive(v, c, s1, s2, d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("stall_hold", stall, 1'b1);
            if (i > 0) check("stall_bubble", ex_valid, 1'b0);
            advance();
        end
        @(negedge clk);
        check("stall_clear", stall, 1'b0);
        check("flush_idle", flush, 1'b0);
        if (v) sb.push_back('{ctrl: wb_expect(c), rd: d});
        advance();
    endtask

    task automatic fwd_check(input string tag, input logic [1:0] a, input logic [1:0] b);
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        check({tag, "_a"}, fwd_a_sel, a);
        check({tag, "_b"}, fwd_b_sel, b);
        check({tag, "_stall"}, stall, 1'b0);
        advance();
    endtask

    initial begin
        #7;
        check("reset_outputs", all_outputs(), 64'd0);
        #5 rst_n = 1'b1;
        advance();
        // load-use: one stall with forwarding, two without
        issue(1, LW, 5'd2, 5'd0, 5'd5, 0);
        issue(1, ADD, 5'd5, 5'd1, 5'd6, FWD ? 1 : 2);
        fwd_check("loaduse_fwd", FWD ? 2'b01 : 2'b00, 2'b00);
        idle(3);
        // back-to-back dependency on both operands
        issue(1, ADD, 5'd1, 5'd2, 5'd3, 0);
        issue(1, ADD, 5'd3, 5'd3, 5'd4, FWD ? 0 : 2);
        fwd_check("b2b_fwd", FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
        idle(3);
        // MEM wins over WB on the same register
        issue(1, ADD, 5'd1, 5'd2, 5'd7, 0);
        issue(1, ADD, 5'd1, 5'd2, 5'd7, 0);
        issue(1, ADD, 5'd7, 5'd7, 5'd8, FWD ? 0 : 2);
        fwd_check("prio_fwd", FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
        idle(3);
        // WB-only forwarding on operand b
        issue(1, ADD, 5'd1, 5'd2, 5'd9, 0);
        issue(0, '0, 5'd0, 5'd0, 5'd0, 0);
        issue(1, ADD, 5'd1, 5'd9, 5'd10, FWD ? 0 : 1);
        fwd_check("wb_fwd", 2'b00, FWD ? 2'b01 : 2'b00);
        idle(3);
        // x0 is never a hazard or forwarding source
        issue(1, ADD, 5'd1, 5'd2, 5'd0, 0);
        issue(1, ADD, 5'd0, 5'd0, 5'd11, 0);
        fwd_check("x0_fwd", 2'b00, 2'b00);
        issue(1, LW, 5'd2, 5'd0, 5'd0, 0);
        issue(1, ADD, 5'd0, 5'd0, 5'd12, 0);
        fwd_check("x0_load", 2'b00, 2'b00);
        idle(3);
        // an empty ID slot cannot cause a load-use stall
        issue(1, LW, 5'd2, 5'd0, 5'd5, 0);
        issue(0, ADD, 5'd5, 5'd5, 5'd6, 0);
        idle(3);
        // taken beq: flush, bubble, and no register write at WB
        issue(1, BEQ, 5'd1, 5'd2, 5'd13, 0);
        drive(1, ADD, 5'd3, 5'd4, 5'd14);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        check("br_flush", flush, 1'b1);
        check("br_stall", stall, 1'b0);
        advance();
        ex_branch_taken = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        check("br_bubble_valid", ex_valid, 1'b0);
        check("br_bubble_ctrl", ex_ctrl, 10'd0);
        advance();
        idle(4);
        // flush overrides a simultaneous load-use stall
        issue(1, LW, 5'd2, 5'd0, 5'd5, 0);
        drive(1, ADD, 5'd5, 5'd1, 5'd6);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        check("ovr_flush", flush, 1'b1);
        check("ovr_stall", stall, 1'b0);
        advance();
        ex_branch_taken = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        check("ovr_bubble", ex_valid, 1'b0);
        advance();
        idle(3);
        // taken indication with an empty EX is ignored
        ex_branch_taken = 1'b1;
        @(negedge clk);
        check("taken_empty_flush", flush, 1'b0);
        advance();
        ex_branch_taken = 1'b0;
        // jumps keep their register write
        issue(1, JAL, 5'd0, 5'd0, 5'd1, 0);
        idle(4);
        // asynchronous reset in the middle of a stall
        issue(1, LW, 5'd2, 5'd0, 5'd5, 0);
        drive(1, ADD, 5'd5, 5'd1, 5'd6);
        @(negedge clk);
        check("rst_pre_stall", stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", all_outputs(), 64'd0);
        sb.delete();
        advance();
        check("rst_held", all_outputs(), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sb.push_back('{ctrl: wb_expect(ADD), rd: 5'd6});
        advance();
        check("rst_reload_valid", ex_valid, 1'b1);
        check("rst_reload_rd", ex_rd_addr, 5'd6);
        idle(5);
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
